keypad_matrix_emulator: RTL and testbench

// - Stands in for the passive 4x4 membrane keypad so the row-scanning keypad controller can be exercised without a physical keypad.
// - Accepts key codes from a testbench, UART bridge or scripted sequencer through a ready/valid FIFO.
// - Plays each code back as a timed press / release on the matrix.
// - Drives active-low column lines in response to the scanner's active-low row strobes.

---
 rtl/keypad_matrix_emulator_if.sv | 10 +
 rtl/keypad_matrix_emulator.sv | 158 +++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_emulator_if.sv
// Key-code handshake between a code source (master) and the keypad emulator (slave).
// A code transfers on any rising clock edge where key_valid and key_ready are both high.
interface keypad_matrix_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Emulates a passive 4x4 membrane keypad: queued hex codes are replayed as timed presses on
// active-low column returns. Define KEYPAD_EMU_BOUNCE_EN to add contact bounce at press start.
//   state   | meaning
//   S_IDLE  | no key played; pops the next queued code when one is available
//   S_PRESS | key held for HOLD_CYCLES (contact closed, or bouncing at the start)
//   S_GAP   | key released for GAP_CYCLES before the next code may be popped
module keypad_matrix_emulator #(
  parameter int HOLD_CYCLES   = 1000000,
  parameter int GAP_CYCLES    = 500000,
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_PERIOD = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  keypad_matrix_emulator_if.slave kp,
  input  logic [3:0]              i_keypad_row,
  output logic [3:0]              o_keypad_col,
  output logic                    o_key_down,
  output logic [3:0]              o_pressed_key,
  output logic                    o_busy,
  output logic [4:0]              o_fifo_count
);
  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);
  localparam logic [4:0]  DEPTH5    = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [4:0]      r_count;
  logic [23:0]     r_cnt;
  logic            r_key_down;
  logic [3:0]      r_pressed_key;
  logic [3:0]      r_col;
  logic            w_push, w_pop;
  logic [7:0]      w_map;

  // {row strobe, column return} that closes the contact for a given code
  function automatic logic [7:0] key_map(input logic [3:0] code);
    case (code)
      4'h0:    key_map = 8'b1110_0111;
      4'h1:    key_map = 8'b1110_1011;
      4'h2:    key_map = 8'b1101_1011;
      4'h3:    key_map = 8'b1011_1011;
      4'h4:    key_map = 8'b1110_1101;
      4'h5:    key_map = 8'b1101_1101;
      4'h6:    key_map = 8'b1011_1101;
      4'h7:    key_map = 8'b1110_1110;
      4'h8:    key_map = 8'b1101_1110;
      4'h9:    key_map = 8'b1011_1110;
      4'hA:    key_map = 8'b1101_0111;
      4'hB:    key_map = 8'b1011_0111;
      4'hC:    key_map = 8'b0111_1110;
      4'hD:    key_map = 8'b0111_1101;
      4'hE:    key_map = 8'b0111_1011;
      default: key_map = 8'b0111_0111;
    endcase
  endfunction

  assign kp.key_ready = (r_count != DEPTH5);
  assign w_push       = kp.key_valid & kp.key_ready;
  assign w_map        = key_map(r_pressed_key);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE:  if (r_count != 5'd0) begin
                 w_pop       = 1'b1;
                 w_state_nxt = S_PRESS;
               end
      S_PRESS: if (r_cnt == HOLD_LAST) w_state_nxt = S_GAP;
      S_GAP:   if (r_cnt == GAP_LAST)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= kp.key_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_pressed_key <= '0;
      r_col         <= 4'hF;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      if (w_state_nxt != r_state)  r_cnt <= '0;
      else if (r_state != S_IDLE)  r_cnt <= r_cnt + 24'd1;
      if (w_pop) begin
        r_pressed_key <= r_mem[r_rd_ptr];
        r_rd_ptr      <= r_rd_ptr + AW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      // Only an exact match of the key's row strobe returns its column
      r_col <= (r_key_down && (i_keypad_row == w_map[7:4])) ? w_map[3:0] : 4'hF;
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [23:0] BNC_LAST = 24'(BOUNCE_PERIOD - 1);
  logic [23:0] r_bnc_tmr;
  logic [3:0]  r_bnc_ph;

  // Eight alternating phases starting closed; the eighth toggle leaves the contact closed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_key_down <= 1'b0;
      r_bnc_tmr  <= '0;
      r_bnc_ph   <= '0;
    end else if (w_pop) begin
      r_key_down <= 1'b1;
      r_bnc_tmr  <= '0;
      r_bnc_ph   <= '0;
    end else if (w_state_nxt != S_PRESS) begin
      r_key_down <= 1'b0;
    end else if (r_bnc_ph != 4'd8) begin
      if (r_bnc_tmr == BNC_LAST) begin
        r_bnc_tmr  <= '0;
        r_bnc_ph   <= r_bnc_ph + 4'd1;
        r_key_down <= ~r_key_down;
      end else begin
        r_bnc_tmr  <= r_bnc_tmr + 24'd1;
      end
    end
  end
`else
  logic w_unused_bounce_cfg;
  assign w_unused_bounce_cfg = (BOUNCE_PERIOD > 0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_key_down <= 1'b0;
    else        r_key_down <= (w_state_nxt == S_PRESS);
  end
`endif

  assign o_keypad_col  = r_col;
  assign o_key_down    = r_key_down;
  assign o_pressed_key = r_pressed_key;
  assign o_busy        = (r_state != S_IDLE) || (r_count != 5'd0);
  assign o_fifo_count  = r_count;
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Randomised bench for keypad_matrix_emulator: a timeline model of queue and press/gap phases
// predicts every output, and a monitor matches each observed press against a code scoreboard.
module tb_keypad_matrix_emulator;
  localparam int HOLD  = 16;
  localparam int GAP   = 8;
  localparam int DEPTH = 4;
  localparam int BP    = 2;

  // Key map table: KTAB[row][col], row/col index i means line i is pulled low
  localparam logic [3:0] KTAB [4][4] = '{'{4'h7, 4'h4, 4'h1, 4'h0},
                                         '{4'h8, 4'h5, 4'h2, 4'hA},
                                         '{4'h9, 4'h6, 4'h3, 4'hB},
                                         '{4'hC, 4'hD, 4'hE, 4'hF}};

  logic       clk;
  logic       rst_b;
  logic [3:0] row_drv;
  logic [3:0] col;
  logic       key_down;
  logic [3:0] pressed_key;
  logic       busy;
  logic [4:0] fifo_count;

  keypad_matrix_emulator_if kp_if ();

  keypad_matrix_emulator #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .BOUNCE_PERIOD(BP)
  ) dut (
    .clock(clk), .reset(rst_b), .kp(kp_if), .i_keypad_row(row_drv),
    .o_keypad_col(col), .o_key_down(key_down), .o_pressed_key(pressed_key),
    .o_busy(busy), .o_fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] sb_q [$];
  logic [3:0] m_fifo [$];
  int         m_left = 0;
  logic [3:0] m_key = 4'h0;
  logic [3:0] m_col = 4'hF;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] key_loc(input logic [3:0] code);
    logic [7:0] res;
    res = 8'hFF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (KTAB[r][c] == code) res = {4'hF ^ (4'h1 << r), 4'hF ^ (4'h1 << c)};
    return res;
  endfunction

  // Contact state implied by the model timeline (m_left counts down through press then gap)
  function automatic logic m_contact();
    if (m_left <= GAP) return 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    begin
      int el;
      el = HOLD + GAP - m_left;
      if (el < 8 * BP && ((el / BP) % 2) == 1) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    sb_q.delete();
    m_left = 0;
    m_key  = 4'h0;
    m_col  = 4'hF;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] code, input logic [3:0] row);
    logic [7:0] rc;
    logic       pre_down;
    int         pre_size;
    pre_down = m_contact();
    rc       = key_loc(m_key);
    pre_size = m_fifo.size();
    m_col    = (pre_down && row == rc[7:4]) ? rc[3:0] : 4'hF;
    if (m_left == 0 && pre_size > 0) begin
      m_key  = m_fifo.pop_front();
      m_left = HOLD + GAP;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (v && pre_size != DEPTH) begin
      m_fifo.push_back(code);
      sb_q.push_back(code);
    end
  endtask

  task automatic compare_all();
    chk("key_down",    int'(key_down),    int'(m_contact()));
    chk("fifo_count",  int'(fifo_count),  m_fifo.size());
    chk("key_ready",   int'(kp_if.key_ready), int'(m_fifo.size() != DEPTH));
    chk("busy",        int'(busy),        int'(m_left > 0 || m_fifo.size() > 0));
    chk("keypad_col",  int'(col),         int'(m_col));
    chk("pressed_key", int'(pressed_key), int'(m_key));
  endtask

  task automatic step(input logic v, input logic [3:0] code, input logic [3:0] row);
    @(negedge clk);
    kp_if.key_valid = v;
    kp_if.key_code  = code;
    row_drv         = row;
    @(posedge clk);
    model_edge(v, code, row);
    #1;
    compare_all();
  endtask

  function automatic logic [3:0] rand_row();
    logic [7:0] rc;
    rc = key_loc(m_key);
    case ($urandom_range(0, 7))
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      3:       return 4'b0111;
      4:       return 4'b1111;
      5:       return 4'b1100;
      6:       return 4'($urandom);
      default: return rc[7:4];
    endcase
  endfunction

  // Press monitor: a rising contact after a long release is a new key
  int   mon_high = 0;
  int   mon_low  = 1000;
  logic mon_prev = 1'b0;
  always @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mon_high = 0;
      mon_low  = 1000;
      mon_prev = 1'b0;
    end else begin
      if (key_down && !mon_prev && mon_low > BP) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL press_order actual=%0d required=no_press at %0t", pressed_key, $time);
        end else begin
          chk("press_order", int'(pressed_key), int'(sb_q.pop_front()));
        end
        mon_high = 0;
      end
`ifndef KEYPAD_EMU_BOUNCE_EN
      if (!key_down && mon_prev) chk("hold_len", mon_high, HOLD);
`endif
      if (key_down) begin
        mon_high++;
        mon_low = 0;
      end else begin
        mon_low++;
      end
      mon_prev = key_down;
    end
  end

  initial begin
    rst_b           = 1'b0;
    kp_if.key_valid = 1'b0;
    kp_if.key_code  = 4'h0;
    row_drv         = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col",   int'(col), 15);
    chk("rst_down",  int'(key_down), 0);
    chk("rst_ready", int'(kp_if.key_ready), 1);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_key",   int'(pressed_key), 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Single key with its own row held
    step(1'b1, 4'h5, 4'b1101);
    repeat (30) step(1'b0, 4'h0, 4'b1101);

    // Row sweep over key F
    step(1'b1, 4'hF, 4'b1110);
    for (int i = 0; i < 32; i++) step(1'b0, 4'h0, 4'hF ^ (4'h1 << (i % 4)));

    // Six codes back-to-back into an empty queue
    for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom), rand_row());
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(kp_if.key_ready), 0);
    repeat (140) step(1'b0, 4'h0, rand_row());

    // Illegal strobes during a press of key 7
    step(1'b1, 4'h7, 4'b1100);
    for (int i = 0; i < 30; i++) step(1'b0, 4'h0, (i % 2 == 0) ? 4'b1100 : 4'b1111);

    // Random traffic
    for (int i = 0; i < 1200; i++)
      step($urandom_range(0, 5) == 0, 4'($urandom), rand_row());
    repeat (150) step(1'b0, 4'h0, rand_row());

    // Reset in the middle of a press with three codes queued
    for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom), rand_row());
    repeat (4) step(1'b0, 4'h0, rand_row());
    @(negedge clk);
    kp_if.key_valid = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_col",   int'(col), 15);
    chk("mid_rst_down",  int'(key_down), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ready", int'(kp_if.key_ready), 1);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 7) == 0, 4'($urandom), rand_row());
    repeat (150) step(1'b0, 4'h0, rand_row());
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
